apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
- APB initiator that drives the shared peripheral bus toward the GPIO and UART slaves.
- Accepts single read/write requests on a valid/ready command port and decodes the address into the 2-bit psel slave select.
- Runs the APB SETUP and ACCESS phases, waiting on pready, and returns one response pulse per request.
- This is the requester side of the bus that the UART slave interface answers.

Parameters:
- GPIO_NIB, 4'h1, value of req_addr[31:28] that selects GPIO (psel=2'b01)
- UART_NIB, 4'h2, value of req_addr[31:28] that selects UART (psel=2'b10)
- TIMEOUT_CYCLES, 255, maximum ACCESS wait cycles before abort (only used with the optional feature); counter width is $clog2(TIMEOUT_CYCLES+1)

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  command present
- req_ready  out  1  bridge can accept a command
- req_write  in  1  1=write, 0=read
- req_addr  in  32  target address
- req_wdata  in  32  write data
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  read data (0 for writes and errors)
- resp_err  out  1  decode error or timeout, qualified by resp_valid
- pAdd  out  32  APB address
- pwData  out  32  APB write data
- pwr  out  1  APB write strobe
- psel  out  2  slave select: 00 none, 01 GPIO, 10 UART
- pen  out  1  APB enable
- prdata  in  32  APB read data
- pready  in  1  slave ready

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, pAdd=0, pwData=0, pwr=0, psel=00, pen=0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- req_ready is 1 only in IDLE.
- A command is accepted when req_valid && req_ready; a command presented while busy is not accepted, and the requester holds it.
- IDLE, accept at edge N, mapped address:
  - Register pAdd/pwData/pwr and drive psel from the decode.
  - Go to SETUP; cycle N+1 shows psel≠0, pen=0.
- SETUP to ACCESS unconditionally; pen=1 from cycle N+2.
- ACCESS holds psel, pen, pAdd, pwData and pwr stable while pready=0.
- ACCESS with pready=1:
  - On a read, capture prdata into resp_rdata.
  - Drop psel to 00 and pen to 0, and go to RESP.
- RESP: resp_valid=1 for exactly one cycle, resp_err=0, then IDLE.
- Minimum latency: accept edge to resp_valid is 3 cycles, with zero wait states.
- Back-to-back commands: the next command can be accepted in the cycle after RESP, so there is one idle cycle between transfers.
- IDLE, accept of an unmapped address (nibble not GPIO_NIB or UART_NIB):
  - No bus cycle; psel stays 00.
  - Go directly to RESP with resp_err=1 and resp_rdata=0.
- Writes return resp_rdata=0.
- pAdd, pwData and pwr keep their last values after a transfer until the next SETUP.
- resp_rdata and resp_err are valid only while resp_valid=1; they may hold their values afterward.
- Reset asserted mid-transfer: psel and pen return to 0 at the next edge, no response is issued, and the state goes to IDLE.
- pready while not in ACCESS is ignored.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to ACCESS and increments on each ACCESS cycle with pready=0.
  - When it reaches TIMEOUT_CYCLES, the bridge drops psel and pen, goes to RESP, and responds with resp_err=1 and resp_rdata=0.
  - If pready=1 arrives in the same cycle the limit is reached, pready wins and the transfer completes normally.
- Undefined: ACCESS waits indefinitely, and resp_err only reports decode errors.

Decomposition:
- Package apb_master_pkg:
  - FSM state enum
  - PSEL_NONE/PSEL_GPIO/PSEL_UART 2-bit constants
  - Default nibble constants
- One natural sub-module: apb_addr_decode, combinational, mapping req_addr[31:28] to psel code plus an unmapped flag.

Test Plan:
- Write 0x2000_0000 data 0xA5, pready=1 immediately -> SETUP: psel=10 pen=0 pwr=1 pAdd=0x2000_0000 pwData=0xA5; ACCESS: pen=1; resp_valid pulses 3 cycles after accept with resp_err=0.
- Read 0x1000_0004, pready low 4 cycles, prdata=0x0000_00F0 when ready -> psel=01 held 5 ACCESS cycles; resp_rdata=0xF0 and resp_valid at accept+7.
- Request to 0x3000_0000 -> psel stays 00, resp_valid the cycle after accept with resp_err=1 and resp_rdata=0.
- Two back-to-back reads with req_valid held -> second accepted in the cycle after the first resp_valid; req_ready=0 throughout each transfer.
- Reset asserted during ACCESS -> next edge psel=00, pen=0, req_ready=1, no resp_valid.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=8, pready never asserted -> abort after 8 wait cycles with resp_err=1; a second run with pready on the 8th cycle completes with resp_err=0.

Source files
------------

// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB master bridge and its address decoder.
package apb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam logic [1:0] PSEL_NONE = 2'b00;
  localparam logic [1:0] PSEL_GPIO = 2'b01;
  localparam logic [1:0] PSEL_UART = 2'b10;

  localparam logic [3:0] DEF_GPIO_NIB = 4'h1;
  localparam logic [3:0] DEF_UART_NIB = 4'h2;

endpackage

// File: rtl/apb_addr_decode.sv
// Maps the top address nibble of a request to an APB slave-select code.
module apb_addr_decode
  import apb_master_pkg::*;
#(
  parameter logic [3:0] GPIO_NIB = DEF_GPIO_NIB,
  parameter logic [3:0] UART_NIB = DEF_UART_NIB
) (
  input  logic [3:0] nib,
  output logic [1:0] psel_code,
  output logic       unmapped
);

  always_comb begin
    psel_code = PSEL_NONE;
    if (nib == GPIO_NIB)      psel_code = PSEL_GPIO;
    else if (nib == UART_NIB) psel_code = PSEL_UART;
    unmapped = (psel_code == PSEL_NONE);
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator toward the GPIO and UART slaves.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYCLES without pready.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter logic [3:0]  GPIO_NIB       = DEF_GPIO_NIB,
  parameter logic [3:0]  UART_NIB       = DEF_UART_NIB,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] pAdd,
  output logic [31:0] pwData,
  output logic        pwr,
  output logic [1:0]  psel,
  output logic        pen,
  input  logic [31:0] prdata,
  input  logic        pready
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t           state, state_nxt;
  logic [1:0]       dec_psel, psel_q;
  logic             dec_unmapped;
  logic             accept, access_done, access_abort;
  logic [CNT_W-1:0] wait_cnt;

  apb_addr_decode #(
    .GPIO_NIB(GPIO_NIB),
    .UART_NIB(UART_NIB)
  ) u_decode (
    .nib      (req_addr[31:28]),
    .psel_code(dec_psel),
    .unmapped (dec_unmapped)
  );

  assign accept      = req_valid && (state == ST_IDLE);
  assign access_done = (state == ST_ACCESS) && pready;
  // pready wins over the limit: abort only fires on a cycle with pready low.
  assign access_abort = TIMEOUT_EN && (state == ST_ACCESS) && !pready && (wait_cnt == CNT_LAST);

  // Counts ACCESS cycles without pready; held at zero outside ACCESS.
  always_ff @(posedge clk) begin
    if (rst || state != ST_ACCESS) wait_cnt <= '0;
    else if (!pready)              wait_cnt <= wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default to holding the state so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (accept) state_nxt = dec_unmapped ? ST_RESP : ST_SETUP;
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (access_done || access_abort) state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_RESP);
    pen        = (state == ST_ACCESS);
    psel       = (state == ST_SETUP || state == ST_ACCESS) ? psel_q : PSEL_NONE;
  end

  // Bus address/data persist across transfers; only a mapped accept reloads them.
  always_ff @(posedge clk) begin
    if (rst) begin
      pAdd       <= '0;
      pwData     <= '0;
      pwr        <= 1'b0;
      psel_q     <= PSEL_NONE;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        if (dec_unmapped) begin
          resp_rdata <= '0;
          resp_err   <= 1'b1;
        end else begin
          pAdd   <= req_addr;
          pwData <= req_wdata;
          pwr    <= req_write;
          psel_q <= dec_psel;
        end
      end
      if (access_done) begin
        resp_rdata <= pwr ? '0 : prdata;
        resp_err   <= 1'b0;
      end else if (access_abort) begin
        resp_rdata <= '0;
        resp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized bench for apb_master_bridge against a per-cycle timeline model.
// Honours APB_MASTER_TIMEOUT_EN the same way the design does.
`timescale 1ns/1ps
module tb_apb_master_bridge;

  localparam int TO   = 8;
  localparam int MAXC = 8000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] pAdd, pwData, prdata;
  logic        pwr, pen, pready;
  logic [1:0]  psel;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .GPIO_NIB      (4'h1),
    .UART_NIB      (4'h2),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .pAdd      (pAdd),
    .pwData    (pwData),
    .pwr       (pwr),
    .psel      (psel),
    .pen       (pen),
    .prdata    (prdata),
    .pready    (pready)
  );

  // Cycle k is the clock period following the k-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Expected outputs per cycle, plus the pready/prdata plan the bench drives.
  bit          e_ready [MAXC];
  logic [1:0]  e_psel  [MAXC];
  bit          e_pen   [MAXC];
  bit          e_rv    [MAXC];
  bit          e_err   [MAXC];
  logic [31:0] e_rdata [MAXC];
  int          pr_mode [MAXC];   // 0 random, 1 hold low, 2 complete
  logic [31:0] pr_data [MAXC];
  int          next_free = 0;    // first cycle the bridge is expected ready

  typedef struct {
    int          at;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
  } bus_t;
  bus_t bus_q[$];
  bus_t cur = '{0, 32'h0, 32'h0, 1'b0};

  function automatic void set_idle(input int k);
    e_ready[k] = 1'b1; e_psel[k] = 2'b00; e_pen[k] = 1'b0; e_rv[k] = 1'b0;
    e_err[k] = 1'b0; e_rdata[k] = 32'h0; pr_mode[k] = 0; pr_data[k] = 32'h0;
  endfunction

  // Transaction accepted in cycle p with w wait states: SETUP p+1, ACCESS w+1 cycles, then RESP.
  function automatic int schedule(input int p, input bit wr, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] rd, input int w);
    int          resp, acc;
    logic [1:0]  code;
    bit          err;
    logic [31:0] rdv;
    code = (addr[31:28] == 4'h1) ? 2'b01 : (addr[31:28] == 4'h2) ? 2'b10 : 2'b00;
    if (code == 2'b00) begin
      resp = p + 1; err = 1'b1; rdv = 32'h0;
    end else begin
      acc = w + 1; err = 1'b0; rdv = wr ? 32'h0 : rd;
`ifdef APB_MASTER_TIMEOUT_EN
      if (w >= TO) begin acc = TO; err = 1'b1; rdv = 32'h0; end
`endif
      e_psel[p+1] = code; e_ready[p+1] = 1'b0;
      for (int k = 0; k < acc; k++) begin
        e_psel[p+2+k] = code; e_pen[p+2+k] = 1'b1; e_ready[p+2+k] = 1'b0; pr_mode[p+2+k] = 1;
      end
      if (!err) begin pr_mode[p+1+acc] = 2; pr_data[p+1+acc] = rd; end
      resp = p + 2 + acc;
      bus_q.push_back('{p + 1, addr, wd, wr});
    end
    e_ready[resp] = 1'b0; e_rv[resp] = 1'b1; e_err[resp] = err; e_rdata[resp] = rdv;
    next_free = resp + 1;
    return resp;
  endfunction

  // Slave side: pready/prdata follow the plan, random where the bridge must ignore them.
  always @(posedge clk) begin
    #1;
    if (cyc < MAXC) begin
      case (pr_mode[cyc])
        1:       pready = 1'b0;
        2:       pready = 1'b1;
        default: pready = 1'($urandom);
      endcase
      prdata = (pr_mode[cyc] == 2) ? pr_data[cyc] : $urandom;
    end
  end

  // Compare process: every cycle after the first edge.
  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      while (bus_q.size() > 0 && bus_q[0].at <= cyc) cur = bus_q.pop_front();
      check("req_ready",  32'(req_ready),  32'(e_ready[cyc]));
      check("psel",       32'(psel),       32'(e_psel[cyc]));
      check("pen",        32'(pen),        32'(e_pen[cyc]));
      check("resp_valid", 32'(resp_valid), 32'(e_rv[cyc]));
      if (e_rv[cyc]) begin
        check("resp_rdata", resp_rdata,     e_rdata[cyc]);
        check("resp_err",   32'(resp_err),  32'(e_err[cyc]));
      end
      check("pAdd",   pAdd,        cur.addr);
      check("pwData", pwData,      cur.wdata);
      check("pwr",    32'(pwr),    32'(cur.wr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg(input int c);
    while (cyc < c) step();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  // Presents a command (held until accepted); returns the accept cycle and response cycle.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int w, input bit keep,
                       output int p, output int rc);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    p  = (cyc > next_free) ? cyc : next_free;
    rc = schedule(p, wr, addr, wd, rd, w);
    while (cyc <= p) step();
    if (!keep) idle_bus();
  endtask

  initial begin
    int p, rc, p2, rc2, r, gap, w;
    logic [3:0] nib;
    for (int k = 0; k < MAXC; k++) set_idle(k);
    idle_bus();
    pready = 1'b0;
    prdata = 32'h0;
    rst    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    at_neg(cyc);
    check("rst_req_ready",  32'(req_ready),  32'd1);
    check("rst_psel",       32'(psel),       32'd0);
    check("rst_pen",        32'(pen),        32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata,      32'h0);
    check("rst_resp_err",   32'(resp_err),   32'd0);
    check("rst_pAdd",       pAdd,            32'h0);
    check("rst_pwr",        32'(pwr),        32'd0);
    step();

    // Zero-wait write to UART
    issue(1'b1, 32'h2000_0000, 32'h0000_00A5, 32'h0, 0, 1'b0, p, rc);
    check("model_wr_latency", 32'(rc - p), 32'd3);
    check("model_wr_setup_psel", 32'(e_psel[p+1]), 32'd2);
    check("model_wr_access_pen", 32'(e_pen[p+2]), 32'd1);
    at_neg(p + 1);
    check("wr_setup_psel",   32'(psel), 32'd2);
    check("wr_setup_pen",    32'(pen),  32'd0);
    check("wr_setup_pwr",    32'(pwr),  32'd1);
    check("wr_setup_pAdd",   pAdd,      32'h2000_0000);
    check("wr_setup_pwData", pwData,    32'h0000_00A5);
    at_neg(p + 2);
    check("wr_access_pen", 32'(pen), 32'd1);
    at_neg(p + 3);
    check("wr_resp_valid", 32'(resp_valid), 32'd1);
    check("wr_resp_err",   32'(resp_err),   32'd0);
    check("wr_resp_rdata", resp_rdata,      32'h0);
    step();

    // GPIO read with four wait states
    issue(1'b0, 32'h1000_0004, 32'h0, 32'h0000_00F0, 4, 1'b0, p, rc);
    check("model_rd_latency", 32'(rc - p), 32'd7);
    at_neg(p + 6);
    check("rd_last_access_psel", 32'(psel), 32'd1);
    check("rd_last_access_pen",  32'(pen),  32'd1);
    at_neg(p + 7);
    check("rd_resp_valid", 32'(resp_valid), 32'd1);
    check("rd_resp_rdata", resp_rdata,      32'h0000_00F0);
    step();

    // Unmapped address
    issue(1'b0, 32'h3000_0000, 32'h0, 32'h0, 0, 1'b0, p, rc);
    check("model_dec_latency", 32'(rc - p), 32'd1);
    at_neg(p + 1);
    check("dec_psel",       32'(psel),       32'd0);
    check("dec_resp_valid", 32'(resp_valid), 32'd1);
    check("dec_resp_err",   32'(resp_err),   32'd1);
    check("dec_resp_rdata", resp_rdata,      32'h0);
    step();

    // Back-to-back reads with req_valid held
    issue(1'b0, 32'h2000_0008, 32'h0, 32'hCAFE_0001, 1, 1'b1, p, rc);
    issue(1'b0, 32'h1000_000C, 32'h0, 32'hCAFE_0002, 0, 1'b0, p2, rc2);
    check("model_b2b_accept", 32'(p2 - rc), 32'd1);
    at_neg(rc2);
    check("b2b_resp_rdata", resp_rdata, 32'hCAFE_0002);
    step();

    // Reset in the middle of ACCESS
    issue(1'b0, 32'h2000_0010, 32'h0, 32'h1234_5678, 10, 1'b0, p, rc);
    while (cyc < p + 3) step();
    rst = 1'b1;
    r   = cyc;
    for (int k = r + 1; k < MAXC; k++) set_idle(k);
    bus_q.push_back('{r + 1, 32'h0, 32'h0, 1'b0});
    next_free = r + 1;
    step();
    rst = 1'b0;
    at_neg(r + 1);
    check("mid_rst_psel",       32'(psel),       32'd0);
    check("mid_rst_pen",        32'(pen),        32'd0);
    check("mid_rst_req_ready",  32'(req_ready),  32'd1);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    step();

`ifdef APB_MASTER_TIMEOUT_EN
    // pready never arrives: abort after TO wait cycles
    issue(1'b0, 32'h1000_0020, 32'h0, 32'h0000_0055, 100, 1'b0, p, rc);
    check("model_to_latency", 32'(rc - p), 32'd10);
    at_neg(rc);
    check("to_resp_valid", 32'(resp_valid), 32'd1);
    check("to_resp_err",   32'(resp_err),   32'd1);
    check("to_resp_rdata", resp_rdata,      32'h0);
    step();
    // pready on the last allowed cycle completes normally
    issue(1'b0, 32'h2000_0024, 32'h0, 32'h0000_0066, 7, 1'b0, p, rc);
    check("model_to_edge_latency", 32'(rc - p), 32'd10);
    at_neg(rc);
    check("to_edge_resp_err",   32'(resp_err), 32'd0);
    check("to_edge_resp_rdata", resp_rdata,    32'h0000_0066);
    step();
`else
    // Without the timeout, a long wait still completes normally
    issue(1'b0, 32'h1000_0020, 32'h0, 32'h0000_0055, 20, 1'b0, p, rc);
    check("model_long_latency", 32'(rc - p), 32'd23);
    at_neg(rc);
    check("long_resp_err",   32'(resp_err), 32'd0);
    check("long_resp_rdata", resp_rdata,    32'h0000_0055);
    step();
`endif

    // Random traffic
    for (int i = 0; i < 150; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      nib = (sel < 4) ? 4'h1 : (sel < 8) ? 4'h2 : (sel == 8) ? 4'h3 : 4'($urandom);
      w   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 12)) : int'($urandom_range(0, 3));
      gap = int'($urandom_range(0, 2));
      issue(1'($urandom), {nib, 28'($urandom)}, $urandom, $urandom, w, gap == 0, p, rc);
      repeat (gap) step();
    end

    idle_bus();
    while (cyc < next_free + 3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
